// File: rtl/ipml_prefetch_fifo_v2_0.sv
// ipml_prefetch_fifo_v2_0: single-clock FWFT FIFO, sync-read RAM plus 2-entry output stage.
// Optional sticky overflow/underflow flags are built when IPML_PFIFO_ERR_FLAG_EN is defined.
module ipml_prefetch_fifo_v2_0 #(
  parameter int DATA_W   = 32,
  parameter int DEPTH_W  = 10,
  parameter int AF_LEVEL = 2**DEPTH_W,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_en,
  output logic                 wr_vld,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_vld,
  input  logic                 rd_en,
  output logic [DEPTH_W+1:0]   level,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);
  localparam int LW = DEPTH_W + 2;
  localparam logic [LW-1:0] CAP_L = LW'(2**DEPTH_W + 2);
  localparam logic [LW-1:0] AF_L  = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L  = LW'(AE_LEVEL);
  logic [DATA_W-1:0] ram [2**DEPTH_W];
  logic [DEPTH_W:0]  wptr, rptr;
  logic [DATA_W-1:0] ram_q, e0, e1, n0, n1;
  logic              inflight, push, pop, issue;
  logic [1:0]        out_cnt;
  logic [LW-1:0]     lvl_d;
  assign push    = wr_en & wr_vld;
  assign pop     = rd_en & rd_vld;
  assign rd_vld  = out_cnt != 2'd0;
  assign rd_data = e0;
  // out_cnt + inflight never exceeds 2, so issuing on a pop cannot overrun the stage
  assign issue   = (wptr != rptr) && ((({1'b0, out_cnt} + {2'b0, inflight}) < 3'd2) || pop);
  assign lvl_d   = flush ? '0 : level + LW'(push) - LW'(pop);
  always_comb begin
    n0 = (inflight && out_cnt == {1'b0, pop}) ? ram_q : (pop ? e1 : e0);
    n1 = (inflight && out_cnt != {1'b0, pop}) ? ram_q : e1;
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) ram[wptr[DEPTH_W-1:0]] <= wr_data;
    if (issue) ram_q <= ram[rptr[DEPTH_W-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      out_cnt  <= 2'd0;
      e0       <= '0;
      e1       <= '0;
    end else begin
      wptr     <= wptr + (DEPTH_W+1)'(push);
      rptr     <= rptr + (DEPTH_W+1)'(issue);
      inflight <= issue;
      out_cnt  <= out_cnt - {1'b0, pop} + {1'b0, inflight};
      e0       <= n0;
      e1       <= n1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      level        <= '0;
      wr_vld       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= lvl_d;
      wr_vld       <= lvl_d < CAP_L;
      almost_full  <= lvl_d >= AF_L;
      almost_empty <= lvl_d <= AE_L;
    end
  end
`ifdef IPML_PFIFO_ERR_FLAG_EN
  // a new error in the clearing cycle wins over clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_err) | (wr_en & ~wr_vld);
      underflow <= (underflow & ~clr_err) | (rd_en & ~rd_vld);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0.sv
// tb_ipml_prefetch_fifo_v2_0: directed scoreboard bench for ipml_prefetch_fifo_v2_0 (DEPTH_W=4).
module tb_ipml_prefetch_fifo_v2_0;
  localparam int DW = 16, AW = 4, CAP = 18;
`ifdef IPML_PFIFO_ERR_FLAG_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic clk = 1'b0, rst, flush, wr_en, wr_vld, rd_vld, rd_en, almost_full, almost_empty;
  logic overflow, underflow, clr_err;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW+1:0] level;
  logic [DW-1:0] q[$];
  int errors = 0, checks = 0, gaps, maxlvl;
  bit seen;
  ipml_prefetch_fifo_v2_0 #(.DATA_W(DW), .DEPTH_W(AW), .AF_LEVEL(CAP), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en), .wr_vld(wr_vld),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_en(rd_en), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // scoreboard monitor: every pop is compared against the oldest accepted word
  always @(negedge clk) begin
    if (!rst && !flush && rd_en && rd_vld) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no word", rd_data);
      end else check("sb_data", rd_data, q.pop_front());
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    if (wr_vld) q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask
  task automatic drain(input int bound);
    rd_en = 1'b1;
    for (int i = 0; i < bound && q.size() > 0; i++) step();
    rd_en = 1'b0;
    check("drain_empty", q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    step(); step();
    check("rst_rd_vld", rd_vld, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_level", level, 0);
    check("rst_af", almost_full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_ov", overflow, 0);
    check("rst_uf", underflow, 0);
    check("rst_wr_vld", wr_vld, 0);
    rst = 1'b0;
    step();
    check("rel_wr_vld", wr_vld, 1);
    // fill to capacity: 16 RAM words + 2 output-stage words
    for (int i = 0; i < CAP; i++) begin
      push_word(DW'(i));
      if (i == 1) check("fill_ae_at2", almost_empty, 1);
      if (i == 2) check("fill_ae_at3", almost_empty, 0);
      if (i == 16) begin
        check("fill17_level", level, 17);
        check("fill17_wr_vld", wr_vld, 1);
        check("fill17_af", almost_full, 0);
      end
    end
    check("full_wr_vld", wr_vld, 0);
    check("full_level", level, 18);
    check("full_af", almost_full, 1);
    wr_en = 1'b1; wr_data = 16'h0099;
    step();
    wr_en = 1'b0;
    check("full_overflow", overflow, ERR);
    check("full_drop_level", level, 18);
    rd_en = 1'b1;
    step();
    check("pop_wr_vld", wr_vld, 1);
    check("pop_level", level, 17);
    check("pop_af", almost_full, 0);
    drain(40);
    check("drained_level", level, 0);
    check("drained_rd_vld", rd_vld, 0);
    check("drained_ae", almost_empty, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ov_cleared", overflow, 0);
    // first-word fall-through latency
    push_word(16'h00A5);
    check("fwft_e0", rd_vld, 0);
    step();
    check("fwft_e1", rd_vld, 0);
    step();
    check("fwft_e2_vld", rd_vld, 1);
    check("fwft_e2_data", rd_data, 16'h00A5);
    check("fwft_level", level, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("fwft_pop_vld", rd_vld, 0);
    check("fwft_pop_level", level, 0);
    check("fwft_pop_ae", almost_empty, 1);
    // streaming push+pop every cycle
    gaps = 0; maxlvl = 0; seen = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(16'h1000 + i);
      if (wr_vld) q.push_back(wr_data);
      step();
      if (rd_vld) seen = 1'b1;
      else if (seen && q.size() > 0) gaps++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      step();
      if (!rd_vld && q.size() > 0) gaps++;
    end
    rd_en = 1'b0;
    check("stream_empty", q.size(), 0);
    check("stream_gaps", gaps, 0);
    check("stream_maxlvl_le3", maxlvl <= 3, 1);
    // random backpressure with pointer wrap
    for (int i = 0; i < 5000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      wr_data = DW'($urandom);
      if (wr_en && wr_vld) q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    drain(60);
    check("rand_level", level, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    // flush with a read in flight and simultaneous push/pop
    for (int i = 0; i < 8; i++) push_word(DW'(16'h0700 + i));
    step(); step();
    check("flush_pre8", level, 8);
    rd_en = 1'b1;
    step();
    check("flush_pre7", level, 7);
    flush = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF;
    q.delete();
    step();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("flush_level", level, 0);
    check("flush_rd_vld", rd_vld, 0);
    check("flush_wr_vld", wr_vld, 1);
    step(); step();
    check("flush_cancel_vld", rd_vld, 0);
    check("flush_cancel_lvl", level, 0);
    push_word(16'h0055);
    for (int i = 0; i < 10 && !rd_vld; i++) step();
    check("flush_next_vld", rd_vld, 1);
    check("flush_next_data", rd_data, 16'h0055);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("flush_next_level", level, 0);
    check("flush_keeps_ov", overflow, 0);
    // sticky error flags
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("uf_set", underflow, ERR);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("uf_clr", underflow, 0);
    rd_en = 1'b1; clr_err = 1'b1;
    step();
    rd_en = 1'b0; clr_err = 1'b0;
    check("uf_clr_collide", underflow, ERR);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("uf_clr2", underflow, 0);
    check("ov_still0", overflow, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
